// File: rtl/store_rmw_ctrl.sv
// Store controller: word stores write directly, byte/half stores read-modify-write the containing word.
// Define STORE_MISALIGN_CHECK_EN to reject misaligned half/word stores and expose misalign_o.
module store_rmw_ctrl #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [ADDR_WIDTH-1:0] req_data_i,
  input  logic [1:0]            mem_type_i,
  output logic                  mem_re_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [ADDR_WIDTH-1:0] mem_wdata_o,
  input  logic [ADDR_WIDTH-1:0] mem_rdata_i,
  output logic                  busy_o,
  output logic                  done_o
`ifdef STORE_MISALIGN_CHECK_EN
  ,
  output logic                  misalign_o
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    READ  = 2'b01,
    WAIT  = 2'b10,
    WRITE = 2'b11
  } state_t;

  state_t                  state_q, state_d;
  logic [1:0]              addr_lo_q, addr_lo_d;
  logic [15:0]             data_q, data_d;
  logic                    is_byte_q, is_byte_d;
  logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
  logic [ADDR_WIDTH-1:0]   mem_wdata_q, mem_wdata_d;
  logic [ADDR_WIDTH-1:0]   merged_word;
  logic [3:0]              lane_sel;

  logic req_is_byte;
  logic req_is_half;
  logic req_is_word;
  logic accept;
  logic misalign_hit;

  assign req_is_byte = (mem_type_i == 2'b01);
  assign req_is_half = (mem_type_i == 2'b10);
  assign req_is_word = (mem_type_i[1] == mem_type_i[0]);
  assign accept      = req_valid_i && (state_q == IDLE);

`ifdef STORE_MISALIGN_CHECK_EN
  logic misalign_q, misalign_d;
  assign misalign_hit = (req_is_half && req_addr_i[0]) ||
                        (req_is_word && (req_addr_i[1:0] != 2'b00));
  assign misalign_o   = misalign_q;
`else
  assign misalign_hit = 1'b0;
`endif

  // Lane merge from the latched request; the read word supplies every untouched lane.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign lane_sel[gi] = is_byte_q ? (addr_lo_q == 2'(gi))
                                    : (addr_lo_q[1] == 1'(gi / 2));
    assign merged_word[8*gi +: 8] = !lane_sel[gi] ? mem_rdata_i[8*gi +: 8] :
                                    is_byte_q      ? data_q[7:0]
                                                   : data_q[8*(gi % 2) +: 8];
  end

  if (ADDR_WIDTH > 32) begin : g_upper
    assign merged_word[ADDR_WIDTH-1:32] = mem_rdata_i[ADDR_WIDTH-1:32];
  end

  always_comb begin
    state_d     = state_q;
    addr_lo_d   = addr_lo_q;
    data_d      = data_q;
    is_byte_d   = is_byte_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
`ifdef STORE_MISALIGN_CHECK_EN
    misalign_d  = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (misalign_hit) begin
`ifdef STORE_MISALIGN_CHECK_EN
            misalign_d = 1'b1;
`endif
          end else begin
            addr_lo_d  = req_addr_i[1:0];
            data_d     = req_data_i[15:0];
            is_byte_d  = req_is_byte;
            mem_addr_d = {req_addr_i[ADDR_WIDTH-1:2], 2'b00};
            if (req_is_word) begin
              mem_wdata_d = req_data_i;
              state_d     = WRITE;
            end else begin
              state_d     = READ;
            end
          end
        end
      end
      READ:    state_d = WAIT;
      WAIT: begin
        mem_wdata_d = merged_word;
        state_d     = WRITE;
      end
      WRITE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_lo_q   <= 2'b00;
      data_q      <= 16'h0000;
      is_byte_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
`ifdef STORE_MISALIGN_CHECK_EN
      misalign_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      addr_lo_q   <= addr_lo_d;
      data_q      <= data_d;
      is_byte_q   <= is_byte_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
`ifdef STORE_MISALIGN_CHECK_EN
      misalign_q  <= misalign_d;
`endif
    end
  end

  // Strobes decode straight from the state, so read and write can never overlap.
  assign req_ready_o = (state_q == IDLE);
  assign busy_o      = (state_q != IDLE);
  assign mem_re_o    = (state_q == READ);
  assign mem_we_o    = (state_q == WRITE);
  assign done_o      = (state_q == WRITE);
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;

endmodule

// File: tb/tb_store_rmw_ctrl.sv
// Directed bench for store_rmw_ctrl: word, byte, half, back-to-back, reset-in-WAIT and
// (with STORE_MISALIGN_CHECK_EN) misalignment cases against hand-computed values.
module tb_store_rmw_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic [1:0]  req_type;
  logic        mem_re;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        busy;
  logic        done;
`ifdef STORE_MISALIGN_CHECK_EN
  logic        misalign;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int we_cnt = 0;
  int re_cnt = 0;
  int overlap_cnt = 0;
  logic [31:0] rd_word = 32'h0;

  store_rmw_ctrl #(.ADDR_WIDTH(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_addr_i  (req_addr),
    .req_data_i  (req_data),
    .mem_type_i  (req_type),
    .mem_re_o    (mem_re),
    .mem_we_o    (mem_we),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .mem_rdata_i (mem_rdata),
    .busy_o      (busy),
    .done_o      (done)
`ifdef STORE_MISALIGN_CHECK_EN
    ,
    .misalign_o  (misalign)
`endif
  );

  always #5 clk = ~clk;

  // Memory model: read data appears one cycle after the read strobe.
  always @(posedge clk) begin
    if (mem_re) mem_rdata <= rd_word;
    if (mem_we) we_cnt <= we_cnt + 1;
    if (mem_re) re_cnt <= re_cnt + 1;
    if (mem_re && mem_we) overlap_cnt <= overlap_cnt + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
    $display("check %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Byte/half store: READ, WAIT, WRITE, then back in IDLE holding the written word.
  task automatic sub_store(input string tag, input logic [31:0] a, input logic [31:0] d,
                           input logic [1:0] t, input logic [31:0] rd, input logic [31:0] exp);
    rd_word = rd; req_addr = a; req_data = d; req_type = t; req_valid = 1'b1;
    @(negedge clk);
    chk({tag, " READ re"},    mem_re, 1);
    chk({tag, " READ addr"},  mem_addr, {a[31:2], 2'b00});
    chk({tag, " READ ready"}, req_ready, 0);
    req_valid = 1'b0; req_addr = 32'hFFFF_FFFF; req_data = 32'hFFFF_FFFF; req_type = 2'b11;
    @(negedge clk);
    chk({tag, " WAIT re/we"}, {mem_re, mem_we}, 0);
    chk({tag, " WAIT busy"},  busy, 1);
    @(negedge clk);
    chk({tag, " WRITE we"},    mem_we, 1);
    chk({tag, " WRITE done"},  done, 1);
    chk({tag, " WRITE addr"},  mem_addr, {a[31:2], 2'b00});
    chk({tag, " WRITE wdata"}, mem_wdata, exp);
    @(negedge clk);
    chk({tag, " IDLE we/done"}, {mem_we, done}, 0);
    chk({tag, " IDLE ready"},   req_ready, 1);
    chk({tag, " IDLE wdata"},   mem_wdata, exp);
  endtask

  int re_before;
  int we_before;

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_addr = 0; req_data = 0; req_type = 0;
    @(negedge clk); @(negedge clk);
    chk("reset ready", req_ready, 1);
    chk("reset busy/re/we/done", {busy, mem_re, mem_we, done}, 0);
    chk("reset addr", mem_addr, 0);
    chk("reset wdata", mem_wdata, 0);
    rst = 1'b0;
    @(negedge clk);

    // Word store
    re_before = re_cnt;
    req_valid = 1'b1; req_addr = 32'h100; req_data = 32'hDEADBEEF; req_type = 2'b00;
    @(negedge clk);
    chk("word we", mem_we, 1);
    chk("word done", done, 1);
    chk("word re", mem_re, 0);
    chk("word addr", mem_addr, 32'h100);
    chk("word wdata", mem_wdata, 32'hDEADBEEF);
    chk("word ready", req_ready, 0);
    req_valid = 1'b0; req_data = 32'h0;
    @(negedge clk);
    chk("word idle we", mem_we, 0);
    chk("word idle wdata hold", mem_wdata, 32'hDEADBEEF);
    chk("word no reads", re_cnt - re_before, 0);

    sub_store("byte3",  32'h103, 32'h0000_00AA, 2'b01, 32'h11223344, 32'hAA223344);
    sub_store("byte1",  32'h101, 32'h0000_005A, 2'b01, 32'hCAFEF00D, 32'hCAFE5A0D);
    sub_store("half2",  32'h202, 32'h0000_BEEF, 2'b10, 32'h11223344, 32'hBEEF3344);
    sub_store("half0",  32'h200, 32'h0000_BEEF, 2'b10, 32'h11223344, 32'h1122BEEF);
`ifndef STORE_MISALIGN_CHECK_EN
    sub_store("half3 lowbit ignored", 32'h203, 32'h0000_1234, 2'b10, 32'hA5A5A5A5, 32'h1234A5A5);
`endif

    // Back-to-back byte requests with valid held high
    rd_word = 32'h11223344;
    req_valid = 1'b1; req_addr = 32'h100; req_data = 32'h77; req_type = 2'b01;
    @(negedge clk);
    chk("b2b READ ready", req_ready, 0);
    @(negedge clk);
    chk("b2b WAIT ready", req_ready, 0);
    @(negedge clk);
    chk("b2b WRITE ready", req_ready, 0);
    chk("b2b WRITE wdata", mem_wdata, 32'h11223377);
    @(negedge clk);
    chk("b2b IDLE ready", req_ready, 1);
    @(negedge clk);
    chk("b2b second READ re", mem_re, 1);
    req_valid = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("b2b second done", done, 1);
    @(negedge clk);

    // Reset while in WAIT
    we_before = we_cnt;
    rd_word = 32'h55555555;
    req_valid = 1'b1; req_addr = 32'h300; req_data = 32'hEE; req_type = 2'b01;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("rst-wait in WAIT busy", busy, 1);
    rst = 1'b1;
    #1;
    chk("rst-wait during rst ready", req_ready, 1);
    chk("rst-wait during rst busy/we", {busy, mem_we}, 0);
    chk("rst-wait during rst addr", mem_addr, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst-wait after ready", req_ready, 1);
    chk("rst-wait after busy", busy, 0);
    @(negedge clk); @(negedge clk);
    chk("rst-wait no write", we_cnt - we_before, 0);

`ifdef STORE_MISALIGN_CHECK_EN
    re_before = re_cnt; we_before = we_cnt;
    req_valid = 1'b1; req_addr = 32'h101; req_data = 32'hBEEF; req_type = 2'b10;
    @(negedge clk);
    req_valid = 1'b0;
    chk("mis half pulse", misalign, 1);
    chk("mis half ready", req_ready, 1);
    chk("mis half busy", busy, 0);
    @(negedge clk);
    chk("mis half pulse end", misalign, 0);
    req_valid = 1'b1; req_addr = 32'h102; req_data = 32'h1; req_type = 2'b11;
    @(negedge clk);
    req_valid = 1'b0;
    chk("mis word pulse", misalign, 1);
    @(negedge clk); @(negedge clk);
    chk("mis no access", (re_cnt - re_before) + (we_cnt - we_before), 0);
`endif

    chk("re/we never overlap", overlap_cnt, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/store_rmw_ctrl.md
STORE_RMW_CTRL -- requirements
Module: store_rmw_ctrl

Interface
REQ-001 The module SHALL have parameter ADDR_WIDTH, default 32, giving the address and data width in bits.
REQ-002 The module SHALL have port clk, input, 1 bit, the single clock; all state updates occur on its rising edge.
REQ-003 The module SHALL have port rst, input, 1 bit, an asynchronous, active-high reset.
REQ-004 The module SHALL have port req_valid_i, input, 1 bit, asserted when a store request is presented.
REQ-005 The module SHALL have port req_ready_o, output, 1 bit, asserted when the controller can accept a request.
REQ-006 The module SHALL have port req_addr_i, input, ADDR_WIDTH bits, the byte address of the store.
REQ-007 The module SHALL have port req_data_i, input, ADDR_WIDTH bits, the store data, right-aligned.
REQ-008 The module SHALL have port mem_type_i, input, 2 bits, the store size: 01 byte, 10 half, 00/11 word.
REQ-009 The module SHALL have port mem_re_o, output, 1 bit, the memory read strobe.
REQ-010 The module SHALL have port mem_we_o, output, 1 bit, the memory write strobe.
REQ-011 The module SHALL have port mem_addr_o, output, ADDR_WIDTH bits, the word-aligned memory address.
REQ-012 The module SHALL have port mem_wdata_o, output, ADDR_WIDTH bits, the full merged word to be written.
REQ-013 The module SHALL have port mem_rdata_i, input, ADDR_WIDTH bits, the read data, valid one cycle after mem_re_o.
REQ-014 The module SHALL have port busy_o, output, 1 bit, high whenever the state is not IDLE.
REQ-015 The module SHALL have port done_o, output, 1 bit, pulsed for one cycle in the WRITE cycle.
REQ-016 The module SHALL have port misalign_o, output, 1 bit, present only when STORE_MISALIGN_CHECK_EN is defined.

Function
REQ-017 The FSM SHALL have states IDLE, READ, WAIT and WRITE; req_ready_o SHALL be 1 only in IDLE.
REQ-018 A request SHALL be accepted when req_valid_i and req_ready_o are both high; the controller SHALL latch addr, data and type on acceptance and ignore later input changes.
REQ-019 On acceptance of a word store, the FSM SHALL go IDLE->WRITE: write occurs one cycle after acceptance.
REQ-020 On acceptance of a byte or half store, the FSM SHALL go IDLE->READ->WAIT->WRITE: the write occurs three cycles after acceptance.
REQ-021 In READ, mem_re_o SHALL be 1 and mem_addr_o SHALL be {addr[ADDR_WIDTH-1:2],2'b00}.
REQ-022 In WAIT, the controller SHALL register the merged word from mem_rdata_i; mem_re_o and mem_we_o SHALL be 0.
REQ-023 Byte merge SHALL replace lane addr[1:0] (bits 8*k+7:8*k) with req_data[7:0] and keep the other lanes from the read word.
REQ-024 Half merge SHALL replace bits [31:16] with req_data[15:0] when addr[1]=1, and otherwise bits [15:0].
REQ-025 A word store SHALL write req_data unmodified without a read.
REQ-026 In WRITE, mem_we_o, done_o SHALL be 1 for exactly one cycle, mem_addr_o SHALL be word-aligned, and the next state SHALL be IDLE.
REQ-027 mem_re_o and mem_we_o SHALL never be high in the same cycle.
REQ-028 Outside READ/WRITE, mem_addr_o and mem_wdata_o SHALL hold their last values; mem_re_o and mem_we_o SHALL be 0.

Reset
REQ-029 While rst is high, the state SHALL be IDLE and mem_re_o, mem_we_o, done_o, busy_o and misalign_o SHALL be 0, with req_ready_o at 1 and mem_addr_o and mem_wdata_o at 0.
REQ-030 A reset asserted mid-operation SHALL abort the pending store with no write issued, including when it arrives in READ or WAIT.

Configuration
REQ-031 With STORE_MISALIGN_CHECK_EN defined:
- an accepted half store with addr[0]=1 or word store with addr[1:0]!=0 SHALL pulse misalign_o for one cycle;
- the FSM SHALL stay in IDLE with no memory access;
- req_ready_o SHALL stay 1.
REQ-032 Without STORE_MISALIGN_CHECK_EN, misalign_o SHALL be absent and the low address bits unused by the merge SHALL be ignored.

Verification
REQ-033 Word store addr=0x100, data=0xDEADBEEF, type=00 -> the cycle after acceptance shows mem_we_o=1, mem_addr_o=0x100, mem_wdata_o=0xDEADBEEF, done_o=1, and mem_re_o is never asserted.
REQ-034 Byte store addr=0x103, data=0x000000AA, read word 0x11223344 -> READ at 0x100, then WRITE of 0xAA223344 three cycles after acceptance.
REQ-035 Half store addr=0x202, data=0x0000BEEF, read word 0x11223344 -> write 0xBEEF3344; the same with addr=0x200 -> write 0x1122BEEF.
REQ-036 Two back-to-back byte requests held valid -> the second is accepted only after done_o, and req_ready_o=0 in READ/WAIT/WRITE.
REQ-037 rst pulsed in WAIT -> no mem_we_o, the state is IDLE, and req_ready_o=1 in the cycle after release.
REQ-038 With STORE_MISALIGN_CHECK_EN, a half store at addr=0x101 -> misalign_o=1 for one cycle with no mem_re_o or mem_we_o.
